clock_set_controller: RTL

- Front-end sequencer for the six-digit HH:MM:SS BCD clock counter.
- Divides the system clock into a one-second tick, debounces the two user buttons, and runs a RUN/SET state machine.
- Drives the counter's settime, upsec, upmin and uphour controls, and the tick that advances seconds.
- Also produces a blink mask that the display driver uses to flash the field being set.

---
 rtl/clock_set_controller_if.sv | 22 ++
 rtl/clock_set_controller.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller_if.sv
// rtl/clock_set_controller_if.sv - button inputs and counter/display controls of the clock set controller
interface clock_set_controller_if;
  logic       btn_mode;
  logic       btn_adv;
  logic       tick;
  logic       settime;
  logic       upsec;
  logic       upmin;
  logic       uphour;
  logic [2:0] blinkmask;
  logic [1:0] state;

  modport master (
    output btn_mode, btn_adv,
    input  tick, settime, upsec, upmin, uphour, blinkmask, state
  );

  modport slave (
    input  btn_mode, btn_adv,
    output tick, settime, upsec, upmin, uphour, blinkmask, state
  );
endinterface

// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - RUN/SET sequencer with one-second prescaler, button debounce and blink mask
// Mode presses walk RUN -> hour -> min -> sec -> RUN; advance presses pulse the field being set.
module clock_set_controller #(
  parameter int unsigned CLK_HZ          = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLINK_DIV       = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  clock_set_controller_if.slave ctl
);

  localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);

  localparam int BTN_MODE = 0;
  localparam int BTN_ADV  = 1;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_SET_HOUR = 2'd1,
    S_SET_MIN  = 2'd2,
    S_SET_SEC  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       deb_q, deb_d, deb_prev_q;
  logic [DEB_W-1:0] dcnt_q [2];
  logic [DEB_W-1:0] dcnt_d [2];
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             settime_q, settime_d;
  logic [2:0]       up_q, up_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic             phase_q, phase_d;
  logic             mode_press, adv_press, blk_wrap;

  // Bit 0 is the mode button, bit 1 the advance button throughout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      dcnt_q     <= '{default: '0};
      pre_q      <= '0;
      tick_q     <= 1'b0;
      settime_q  <= 1'b0;
      up_q       <= 3'b000;
      blk_q      <= '0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= {ctl.btn_adv, ctl.btn_mode};
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      dcnt_q     <= dcnt_d;
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      settime_q  <= settime_d;
      up_q       <= up_d;
      blk_q      <= blk_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    deb_d  = deb_q;
    dcnt_d = '{default: '0};
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_MAX) begin
          deb_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  assign mode_press = deb_q[BTN_MODE] & ~deb_prev_q[BTN_MODE];
  assign adv_press  = deb_q[BTN_ADV] & ~deb_prev_q[BTN_ADV];

  always_comb begin
    state_d = state_q;
    if (mode_press) begin
      case (state_q)
        S_RUN:      state_d = S_SET_HOUR;
        S_SET_HOUR: state_d = S_SET_MIN;
        S_SET_MIN:  state_d = S_SET_SEC;
        default:    state_d = S_RUN;
      endcase
    end
  end

  // A mode press in the same cycle swallows the advance press.
  always_comb begin
    up_d = 3'b000;
    if (adv_press && !mode_press) begin
      case (state_q)
        S_SET_HOUR: up_d = 3'b100;
        S_SET_MIN:  up_d = 3'b010;
        S_SET_SEC:  up_d = 3'b001;
        default:    up_d = 3'b000;
      endcase
    end
  end

  // Prescaler only runs while staying in RUN, so re-entry always restarts a full second.
  always_comb begin
    pre_d  = '0;
    tick_d = 1'b0;
    if (state_q == S_RUN && state_d == S_RUN) begin
      if (pre_q == PRE_MAX) begin
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  assign settime_d = (state_d != S_RUN);
  assign blk_wrap  = (blk_q == BLK_MAX);

  always_comb begin
    blk_d   = blk_wrap ? '0 : blk_q + BLK_W'(1);
    phase_d = phase_q;
    if (state_d != state_q) begin
      phase_d = 1'b1;
    end else if (blk_wrap) begin
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    ctl.blinkmask = 3'b000;
    case (state_q)
      S_SET_HOUR: ctl.blinkmask = {phase_q, 2'b00};
      S_SET_MIN:  ctl.blinkmask = {1'b0, phase_q, 1'b0};
      S_SET_SEC:  ctl.blinkmask = {2'b00, phase_q};
      default:    ctl.blinkmask = 3'b000;
    endcase
  end

  assign ctl.tick    = tick_q;
  assign ctl.settime = settime_q;
  assign ctl.uphour  = up_q[2];
  assign ctl.upmin   = up_q[1];
  assign ctl.upsec   = up_q[0];
  assign ctl.state   = state_q;

endmodule
